datapath_pipe_hs: RTL and testbench

//  Parametrised N-bit signed arithmetic/logic datapath with a STAGES-deep pipeline and valid/ready handshakes.

---
 rtl/datapath_pipe_hs.sv | 129 ++++++++++++
 tb/tb_datapath_pipe_hs.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_pipe_hs.sv
// Signed N-bit ALU/MUL datapath followed by a STAGES-deep valid/ready pipeline.
// A single global advance enable moves every stage at once; bubbles stay in place.
module datapath_pipe_hs #(
  parameter int unsigned N      = 16,
  parameter int unsigned STAGES = 2,
  parameter int unsigned SAT    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] A,
  input  logic signed [N-1:0] B,
  input  logic [2:0]          opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        Y,
  output logic                co,
  output logic                ovf
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_MUL  = 3'b101,
    OP_RELU = 3'b110,
    OP_MAX  = 3'b111
  } op_e;

  localparam logic [N-1:0] Y_POS_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] Y_NEG_MIN = {1'b1, {(N-1){1'b0}}};

  op_e                  op;
  logic [N:0]           add_s;
  logic [N:0]           sub_s;
  logic signed [2*N-1:0] prod;
  logic [N:0]           prod_hi;

  logic [N-1:0]         res_y;
  logic                 res_co;
  logic                 res_ovf;
  logic                 res_neg;

  logic                 adv;
  logic [STAGES-1:0]    v_q;
  logic [N-1:0]         y_q   [STAGES];
  logic [STAGES-1:0]    co_q;
  logic [STAGES-1:0]    ovf_q;

  assign op      = op_e'(opcode);
  assign add_s   = {1'b0, A} + {1'b0, B};
  assign sub_s   = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, 1'b1};
  assign prod    = A * B;
  // Product fits N signed bits only if its top N+1 bits are a pure sign extension.
  assign prod_hi = prod[2*N-1:N-1];

  always_comb begin
    res_y   = '0;
    res_co  = 1'b0;
    res_ovf = 1'b0;
    res_neg = 1'b0;
    case (op)
      OP_ADD: begin
        res_y   = add_s[N-1:0];
        res_co  = add_s[N];
        res_ovf = (A[N-1] == B[N-1]) && (add_s[N-1] != A[N-1]);
        res_neg = A[N-1];
      end
      OP_SUB: begin
        res_y   = sub_s[N-1:0];
        res_co  = sub_s[N];
        res_ovf = (A[N-1] != B[N-1]) && (sub_s[N-1] != A[N-1]);
        res_neg = A[N-1];
      end
      OP_AND:  res_y = A & B;
      OP_OR:   res_y = A | B;
      OP_XOR:  res_y = A ^ B;
      OP_MUL: begin
        res_y   = prod[N-1:0];
        res_ovf = !((&prod_hi) || !(|prod_hi));
        res_neg = prod[2*N-1];
      end
      OP_RELU: res_y = A[N-1] ? '0 : A;
      OP_MAX:  res_y = (A > B) ? A : B;
      default: res_y = '0;
    endcase
    // On overflow the true result's sign is the operand sign (ADD/SUB) or the full product sign.
    if ((SAT != 0) && res_ovf) begin
      res_y = res_neg ? Y_NEG_MIN : Y_POS_MAX;
    end
  end

  assign adv       = ~v_q[STAGES-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign Y         = y_q[STAGES-1];
  assign co        = co_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      co_q  <= '0;
      ovf_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        y_q[i] <= '0;
      end
    end else if (adv) begin
      v_q[0] <= in_valid;
      if (in_valid) begin
        y_q[0]   <= res_y;
        co_q[0]  <= res_co;
        ovf_q[0] <= res_ovf;
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) begin
          y_q[i]   <= y_q[i-1];
          co_q[i]  <= co_q[i-1];
          ovf_q[i] <= ovf_q[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_datapath_pipe_hs.sv
// Directed bench for datapath_pipe_hs: wrap and saturating instances share one stimulus.
module tb_datapath_pipe_hs;

  localparam int N = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b1;
  logic [2:0]         opcode = 3'd0;
  logic signed [N-1:0] A = '0;
  logic signed [N-1:0] B = '0;

  logic               in_ready, out_valid, co, ovf;
  logic [N-1:0]       Y;
  logic               s_in_ready, s_out_valid, s_co, s_ovf;
  logic [N-1:0]       s_Y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  datapath_pipe_hs #(.N(N), .STAGES(2), .SAT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .co(co), .ovf(ovf)
  );

  datapath_pipe_hs #(.N(N), .STAGES(2), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .A(A), .B(B), .opcode(opcode), .out_valid(s_out_valid), .out_ready(out_ready),
    .Y(s_Y), .co(s_co), .ovf(s_ovf)
  );

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic [N-1:0] y;
    logic         c;
    logic         o;
    logic [N-1:0] ys;
  } vec_t;

  vec_t tbl [16] = '{
    '{16'h0005, 16'h0007, 3'd1, 16'hFFFE, 1'b0, 1'b0, 16'hFFFE},
    '{16'hFFF7, 16'h0000, 3'd6, 16'h0000, 1'b0, 1'b0, 16'h0000},
    '{16'hFFFD, 16'hFFF8, 3'd7, 16'hFFFD, 1'b0, 1'b0, 16'hFFFD},
    '{16'h012C, 16'h00C8, 3'd5, 16'hEA60, 1'b0, 1'b1, 16'h7FFF},
    '{16'h8000, 16'h0001, 3'd1, 16'h7FFF, 1'b1, 1'b1, 16'h8000},
    '{16'h8000, 16'h8000, 3'd5, 16'h0000, 1'b0, 1'b1, 16'h7FFF},
    '{16'hFF00, 16'h0080, 3'd5, 16'h8000, 1'b0, 1'b0, 16'h8000},
    '{16'hFFFE, 16'h0003, 3'd5, 16'hFFFA, 1'b0, 1'b0, 16'hFFFA},
    '{16'hF0F0, 16'h3C3C, 3'd2, 16'h3030, 1'b0, 1'b0, 16'h3030},
    '{16'hF0F0, 16'h3C3C, 3'd3, 16'hFCFC, 1'b0, 1'b0, 16'hFCFC},
    '{16'hF0F0, 16'h3C3C, 3'd4, 16'hCCCC, 1'b0, 1'b0, 16'hCCCC},
    '{16'hFFFF, 16'hFFFF, 3'd0, 16'hFFFE, 1'b1, 1'b0, 16'hFFFE},
    '{16'h8000, 16'h8000, 3'd0, 16'h0000, 1'b1, 1'b1, 16'h8000},
    '{16'h0005, 16'hFFF9, 3'd7, 16'h0005, 1'b0, 1'b0, 16'h0005},
    '{16'h7FFF, 16'h0000, 3'd6, 16'h7FFF, 1'b0, 1'b0, 16'h7FFF},
    '{16'h7FFF, 16'hFFFF, 3'd1, 16'h8000, 1'b0, 1'b1, 16'h7FFF}
  };

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || Y !== '0 || co !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b Y=%h co=%b ovf=%b, expected all 0", out_valid, Y, co, ovf);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b v=%b, expected in_ready=1 v=0", in_ready, out_valid);
    end
    step();
  endtask

  task automatic test_add();
    A = 16'sd100; B = -16'sd30; opcode = 3'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_latency1: got v=%b, expected 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || Y !== 16'd70 || co !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_result: got v=%b Y=%h co=%b ovf=%b, expected v=1 Y=0046 co=1 ovf=0",
               out_valid, Y, co, ovf);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_single_cycle: got v=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_overflow_sat();
    A = 16'sd32767; B = 16'sd1; opcode = 3'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || Y !== 16'h8000 || co !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_wrap: got v=%b Y=%h co=%b ovf=%b, expected v=1 Y=8000 co=0 ovf=1",
               out_valid, Y, co, ovf);
    end
    checks++;
    if (s_out_valid !== 1'b1 || s_Y !== 16'h7FFF || s_co !== 1'b0 || s_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sat: got v=%b Y=%h co=%b ovf=%b, expected v=1 Y=7fff co=0 ovf=1",
               s_out_valid, s_Y, s_co, s_ovf);
    end
    step();
  endtask

  task automatic test_ops();
    for (int i = 0; i < 16; i++) begin
      A = tbl[i].a; B = tbl[i].b; opcode = tbl[i].op; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1 || Y !== tbl[i].y || co !== tbl[i].c || ovf !== tbl[i].o) begin
        errors++;
        $display("FAIL ops_wrap[%0d]: got v=%b Y=%h co=%b ovf=%b, expected v=1 Y=%h co=%b ovf=%b",
                 i, out_valid, Y, co, ovf, tbl[i].y, tbl[i].c, tbl[i].o);
      end
      checks++;
      if (s_out_valid !== 1'b1 || s_Y !== tbl[i].ys || s_co !== tbl[i].c || s_ovf !== tbl[i].o) begin
        errors++;
        $display("FAIL ops_sat[%0d]: got v=%b Y=%h co=%b ovf=%b, expected v=1 Y=%h co=%b ovf=%b",
                 i, s_out_valid, s_Y, s_co, s_ovf, tbl[i].ys, tbl[i].c, tbl[i].o);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int stall_left = 0;
    int cyc = 0;
    logic [N-1:0] exp_y;
    while (got < 6 && cyc < 40) begin
      out_ready = (stall_left == 0);
      in_valid  = (sent < 6);
      A = N'(sent * 10 + 1); B = N'(sent); opcode = 3'd0;
      #1;
      if (stall_left != 0) begin
        exp_y = N'(got * 11 + 1);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || Y !== exp_y) begin
          errors++;
          $display("FAIL stall_hold: got in_ready=%b v=%b Y=%h, expected in_ready=0 v=1 Y=%h",
                   in_ready, out_valid, Y, exp_y);
        end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        exp_y = N'(got * 11 + 1);
        checks++;
        if (Y !== exp_y) begin
          errors++;
          $display("FAIL stream_order[%0d]: got Y=%h, expected Y=%h", got, Y, exp_y);
        end
        got++;
        if (got == 2) stall_left = 4;
      end
      if (stall_left != 0) stall_left--;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 6 || sent != 6) begin
      errors++;
      $display("FAIL stream_count: got results=%0d sent=%0d, expected 6 and 6", got, sent);
    end
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_no_dup: got v=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    A = 16'sd1; B = 16'sd2; opcode = 3'd0; in_valid = 1'b1;
    step();
    A = 16'sd10; B = 16'sd20;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || Y !== 16'd3) begin
      errors++;
      $display("FAIL midflight_pre: got v=%b Y=%h, expected v=1 Y=0003", out_valid, Y);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || Y !== '0 || co !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midflight_rst: got v=%b Y=%h co=%b ovf=%b, expected all 0", out_valid, Y, co, ovf);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midflight_stale[%0d]: got v=%b Y=%h, expected v=0", i, out_valid, Y);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow_sat();
    test_ops();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
